// File: rtl/spi_pkg.sv
// Shared types for the SPI master controller: FSM states, SPI mode and a
// small helper that sizes counters and indices safely for small parameters.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    DONE
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_if.sv
// SPI bus bundle: one clock, one data line each way and a one-hot-low
// slave-select vector sized by the number of slaves on the bus.
interface Spi #(
  parameter int NumberOfSlaves = 4
) ();

  logic                      sclk;
  logic                      mosi;
  logic                      miso;
  logic [NumberOfSlaves-1:0] nss;

  modport MasterSpi (output sclk, output mosi, output nss, input miso);
  modport SlaveSpi  (input sclk, input mosi, input nss, output miso);

endinterface

// File: rtl/spi_clock_gen.sv
// Divides clk into sclk half-periods and flags which clk edge moves sclk
// to its leading or trailing level; sclk itself is the phase xor cpol.
module spi_clock_gen
  import spi_pkg::*;
#(
  parameter int ClockDivider = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic toggle_en,
  input  logic cpol,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int CntW = cnt_width(ClockDivider);

  logic [CntW-1:0] cnt_q;
  logic            phase_q;

  assign tick  = count_en && (cnt_q == CntW'(ClockDivider - 1));
  assign lead  = tick && toggle_en && !phase_q;
  assign trail = tick && toggle_en && phase_q;
  assign sclk  = cpol ^ phase_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      if (!count_en || tick) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 1'b1;

      if (!toggle_en) phase_q <= 1'b0;
      else if (tick)  phase_q <= ~phase_q;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: accepts one transfer request at a time, selects one slave,
// shifts DataWidth bits MSB first in any cpol/cpha mode, then pulses done.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter  int NumberOfSlaves = 4,
  parameter  int DataWidth      = 8,
  parameter  int ClockDivider   = 4,
  localparam int SidW           = cnt_width(NumberOfSlaves)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SidW-1:0]      slave_id,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DataWidth-1:0] tx_data,
  output logic [DataWidth-1:0] rx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  Spi.MasterSpi                spi
);

  localparam int HalfW = cnt_width(2 * DataWidth);

  state_t                    state_q, state_d;
  spi_mode_t                 mode_q;
  logic [SidW-1:0]           sid_q;
  logic [DataWidth-1:0]      tx_sr, rx_sr, rx_data_q;
  logic [HalfW-1:0]          half_q;
  logic                      mosi_q, done_q, err_q;
  logic                      tick, lead, trail, sclk;
  logic                      sid_valid, accept, in_xfer, shift_edge, sample_edge;
  logic [NumberOfSlaves-1:0] nss_v;

  assign sid_valid   = int'(slave_id) < NumberOfSlaves;
  assign accept      = (state_q == IDLE) && start && sid_valid;
  assign in_xfer     = (state_q == TRANSFER);
  assign shift_edge  = mode_q.cpha ? lead : trail;
  assign sample_edge = mode_q.cpha ? trail : lead;

  spi_clock_gen #(
    .ClockDivider(ClockDivider)
  ) u_clock_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en ((state_q == SETUP) || in_xfer),
    .toggle_en(in_xfer),
    .cpol     (mode_q.cpol),
    .tick     (tick),
    .lead     (lead),
    .trail    (trail),
    .sclk     (sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default first, otherwise unlisted paths infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = SETUP;
      SETUP:    if (tick) state_d = TRANSFER;
      TRANSFER: if (tick && (half_q == HalfW'(2 * DataWidth - 1))) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      sid_q     <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      half_q    <= '0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      err_q  <= (state_q == IDLE) && start && !sid_valid;

      if (!in_xfer)  half_q <= '0;
      else if (tick) half_q <= half_q + 1'b1;

      if (accept) begin
        mode_q <= '{cpol: cpol, cpha: cpha};
        sid_q  <= slave_id;
        rx_sr  <= '0;
        // cpha=0 must present the MSB before the first (sampling) edge.
        if (cpha) begin
          tx_sr <= tx_data;
        end else begin
          mosi_q <= tx_data[DataWidth-1];
          tx_sr  <= {tx_data[DataWidth-2:0], 1'b0};
        end
      end

      if (shift_edge) begin
        mosi_q <= tx_sr[DataWidth-1];
        tx_sr  <= {tx_sr[DataWidth-2:0], 1'b0};
      end

      if (sample_edge) rx_sr <= {rx_sr[DataWidth-2:0], spi.miso};

      if (state_q == DONE) rx_data_q <= rx_sr;
    end
  end

  always_comb begin
    nss_v = '1;
    if ((state_q == SETUP) || in_xfer) nss_v[sid_q] = 1'b0;
  end

  assign spi.sclk = sclk;
  assign spi.mosi = mosi_q;
  assign spi.nss  = nss_v;
  assign rx_data  = rx_data_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: randomised transfers against a bit-level slave
// model, plus error, back-to-back and reset-abort scenarios.
module tb_spi_master_ctrl;

  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int ACT = CD * (2 * DW + 1);  // cycles with a slave selected
  localparam int LAT = ACT + 1;            // accept edge to done

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, cpol, cpha;
  logic [1:0]    slave_id;
  logic [DW-1:0] tx_data, rx_data;
  logic          busy, done, err;

  logic          start5;
  logic [2:0]    slave_id5;
  logic [DW-1:0] rx_data5;
  logic          busy5, done5, err5;

  logic loopback, miso_r;
  logic idle_cpol;
  int   errors = 0;
  int   checks = 0;

  Spi #(.NumberOfSlaves(4)) spi4 ();
  Spi #(.NumberOfSlaves(5)) spi5 ();

  assign spi4.miso = loopback ? spi4.mosi : miso_r;
  assign spi5.miso = spi5.mosi;

  spi_master_ctrl #(.NumberOfSlaves(4), .DataWidth(DW), .ClockDivider(CD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slave_id(slave_id), .cpol(cpol),
    .cpha(cpha), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .err(err), .spi(spi4)
  );

  spi_master_ctrl #(.NumberOfSlaves(5), .DataWidth(DW), .ClockDivider(CD)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .slave_id(slave_id5), .cpol(1'b0),
    .cpha(1'b0), .tx_data(8'h5A), .rx_data(rx_data5), .busy(busy5), .done(done5),
    .err(err5), .spi(spi5)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (spi4.nss !== 4'hF) begin errors++; $display("FAIL reset_nss: got %h expected f", spi4.nss); end
    checks++; if (spi4.sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", spi4.sclk); end
    checks++; if (spi4.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", spi4.mosi); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cpol = 1'b0;
  endtask

  // One full transfer on the 4-slave DUT with a bit-level slave model that
  // shifts out pat and captures mosi on the edges the mode dictates.
  task automatic run_xfer(input logic [1:0] sid, input logic pol, input logic pha,
                          input logic [7:0] tx, input logic [7:0] pat, input logic lb,
                          input string name);
    logic [3:0] sel;
    logic [3:0] exp_nss;
    logic [7:0] exp_rx, slv_sr, slv_rx;
    logic       prev;
    int tog = 0, nss_err = 0, oh_err = 0, busy_err = 0, done_cnt = 0, done_cyc = 0;
    sel = 4'hF;
    sel[sid] = 1'b0;
    exp_rx = lb ? tx : pat;
    @(negedge clk);
    checks++; if (spi4.sclk !== idle_cpol) begin errors++; $display("FAIL %s_sclk_idle_before: got %b expected %b", name, spi4.sclk, idle_cpol); end
    slave_id = sid; cpol = pol; cpha = pha; tx_data = tx; loopback = lb; start = 1'b1;
    slv_rx = 8'h00;
    if (pha) begin miso_r = 1'b0; slv_sr = pat; end
    else begin miso_r = pat[7]; slv_sr = {pat[6:0], 1'b0}; end
    @(posedge clk); #1;
    start = 1'b0;
    slave_id = 2'($urandom); cpol = 1'($urandom); cpha = 1'($urandom); tx_data = 8'($urandom);
    prev = spi4.sclk;
    checks++; if (spi4.nss !== sel) begin errors++; $display("FAIL %s_nss_select: got %b expected %b", name, spi4.nss, sel); end
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      if (spi4.sclk !== prev) begin
        tog++;
        if ((spi4.sclk != pol) == !pha) slv_rx = {slv_rx[6:0], spi4.mosi};
        else begin miso_r = slv_sr[7]; slv_sr = {slv_sr[6:0], 1'b0}; end
      end
      prev = spi4.sclk;
      exp_nss = (k < ACT) ? sel : 4'hF;
      if (spi4.nss !== exp_nss) nss_err++;
      if ($countones(~spi4.nss) > 1) oh_err++;
      if (busy !== (k <= LAT)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
        checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL %s_rx_data: got %h expected %h", name, rx_data, exp_rx); end
      end
    end
    checks++; if (done_cyc != LAT) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, done_cyc, LAT); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt); end
    checks++; if (tog != 2 * DW) begin errors++; $display("FAIL %s_sclk_toggles: got %0d expected %0d", name, tog, 2 * DW); end
    checks++; if (nss_err != 0) begin errors++; $display("FAIL %s_nss_timeline: got %0d bad cycles expected 0", name, nss_err); end
    checks++; if (oh_err != 0) begin errors++; $display("FAIL %s_nss_onehot: got %0d bad cycles expected 0", name, oh_err); end
    checks++; if (busy_err != 0) begin errors++; $display("FAIL %s_busy: got %0d bad cycles expected 0", name, busy_err); end
    checks++; if (slv_rx !== tx) begin errors++; $display("FAIL %s_mosi_word: got %h expected %h", name, slv_rx, tx); end
    checks++; if (spi4.sclk !== pol) begin errors++; $display("FAIL %s_sclk_idle_after: got %b expected %b", name, spi4.sclk, pol); end
    checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL %s_rx_hold: got %h expected %h", name, rx_data, exp_rx); end
    idle_cpol = pol;
  endtask

  task automatic test_directed();
    run_xfer(2'd0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, "mode0_loop");
    run_xfer(2'd2, 1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, "mode3_pat");
    run_xfer(2'd2, 1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, "mode3_again");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_xfer(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom),
               8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_err();
    int done_cnt, sel_cnt;
    for (int id = 5; id <= 7; id += 2) begin
      done_cnt = 0; sel_cnt = 0;
      @(negedge clk);
      slave_id5 = 3'(id); start5 = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0;
      checks++; if (err5 !== 1'b1) begin errors++; $display("FAIL err_pulse_id%0d: got %b expected 1", id, err5); end
      @(posedge clk); #1;
      checks++; if (err5 !== 1'b0) begin errors++; $display("FAIL err_single_id%0d: got %b expected 0", id, err5); end
      for (int k = 0; k < LAT + 4; k++) begin
        @(posedge clk); #1;
        if (done5 === 1'b1) done_cnt++;
        if (spi5.nss !== 5'h1F || busy5 !== 1'b0) sel_cnt++;
      end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL err_no_done_id%0d: got %0d expected 0", id, done_cnt); end
      checks++; if (sel_cnt != 0) begin errors++; $display("FAIL err_stays_idle_id%0d: got %0d bad cycles expected 0", id, sel_cnt); end
    end
    @(negedge clk);
    slave_id5 = 3'd4; start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    checks++; if (spi5.nss !== 5'b01111) begin errors++; $display("FAIL nss_slave4: got %b expected 01111", spi5.nss); end
    checks++; if (err5 !== 1'b0) begin errors++; $display("FAIL err_valid_id4: got %b expected 0", err5); end
    repeat (LAT + 2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int done_q[$];
    int gap = 0, oh_err = 0;
    @(negedge clk);
    slave_id = 2'd1; cpol = 1'b0; cpha = 1'b0; tx_data = 8'h01; loopback = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h80;
    for (int k = 1; k <= 2 * LAT + 6; k++) begin
      @(posedge clk); #1;
      if (k == LAT + 1) start = 1'b0;
      if ($countones(~spi4.nss) > 1) oh_err++;
      if (done === 1'b1) begin
        done_q.push_back(k);
        checks++;
        if (rx_data !== ((done_q.size() == 1) ? 8'h01 : 8'h80)) begin
          errors++; $display("FAIL b2b_rx%0d: got %h expected %h", done_q.size(), rx_data, (done_q.size() == 1) ? 8'h01 : 8'h80);
        end
      end
      if (k >= ACT && k <= LAT && spi4.nss === 4'hF) gap++;
    end
    checks++; if (done_q.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_q.size()); end
    checks++; if (done_q.size() >= 1 && done_q[0] != LAT) begin errors++; $display("FAIL b2b_first_done: got %0d expected %0d", done_q[0], LAT); end
    checks++; if (done_q.size() >= 2 && done_q[1] != 2 * LAT + 1) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d", done_q[1], 2 * LAT + 1); end
    checks++; if (gap < 1) begin errors++; $display("FAIL b2b_nss_gap: got %0d expected >=1", gap); end
    checks++; if (oh_err != 0) begin errors++; $display("FAIL b2b_nss_onehot: got %0d expected 0", oh_err); end
    idle_cpol = 1'b0;
  endtask

  task automatic test_reset_abort();
    int tog = 0, done_cnt = 0;
    logic prev;
    @(negedge clk);
    slave_id = 2'd3; cpol = 1'b1; cpha = 1'b0; tx_data = 8'hE7; loopback = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev = spi4.sclk;
    for (int k = 0; k < LAT && tog < 7; k++) begin
      @(posedge clk); #1;
      if (spi4.sclk !== prev) tog++;
      prev = spi4.sclk;
    end
    checks++; if (tog != 7) begin errors++; $display("FAIL abort_reach_toggle7: got %0d expected 7", tog); end
    rst_n = 1'b0;
    #1;
    checks++; if (spi4.nss !== 4'hF) begin errors++; $display("FAIL abort_nss: got %b expected 1111", spi4.nss); end
    checks++; if (spi4.sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", spi4.sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx: got %h expected 00", rx_data); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    idle_cpol = 1'b0;
    run_xfer(2'd1, 1'b0, 1'b1, 8'h96, 8'h4B, 1'b0, "after_abort");
  endtask

  initial begin
    start = 1'b0; cpol = 1'b0; cpha = 1'b0; slave_id = 2'd0; tx_data = 8'h00;
    start5 = 1'b0; slave_id5 = 3'd0; loopback = 1'b1; miso_r = 1'b0; idle_cpol = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_err();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
